conv_window_sequencer: RTL and testbench

- Sequences the 3-row circular line-buffer register file that feeds the 3x3 convolution datapath.
- Accepts a raster-order pixel stream and generates write enable and write address for the buffer.
- For each accepted pixel, generates three read addresses (top, mid and bottom row taps of the current column), a column-valid strobe, and a full-window strobe with window coordinates.
- Controls the read/write address counters; the datapath itself is outside this block.

---
 rtl/conv_window_sequencer.sv | 106 ++++++++++
 tb/tb_conv_window_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: write/read address sequencing for a 3-row circular line buffer feeding a 3x3 window
module conv_window_sequencer #(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic       rd_en,
  output logic [3:0] rd_addr_top,
  output logic [3:0] rd_addr_mid,
  output logic [3:0] rd_addr_bot,
  output logic       win_valid,
  output logic [7:0] win_row,
  output logic [7:0] win_col,
  output logic       busy,
  output logic       done
);
  localparam int DEPTH = 3 * IMG_W;
  localparam logic [3:0] PTR_MAX = 4'(DEPTH - 1);
  localparam logic [7:0] C_MAX = 8'(IMG_W - 1);
  localparam logic [7:0] R_MAX = 8'(IMG_H - 1);
  localparam logic [4:0] DEP5 = 5'(DEPTH);
  localparam logic [4:0] W1 = 5'(IMG_W);
  localparam logic [4:0] W2 = 5'(2 * IMG_W);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t state_q, state_d;
  logic [3:0] ptr_q, ptr_d, top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [7:0] r_q, r_d, c_q, c_d, win_row_q, win_row_d, win_col_q, win_col_d;
  logic rd_en_q, rd_en_d, win_valid_q, win_valid_d, acc, last_col;
  logic [4:0] sum_top, sum_mid;
  always_comb begin
    in_ready = (state_q == STREAM) && !stall;
    acc = in_valid && in_ready;
    last_col = c_q == C_MAX;
    sum_top = {1'b0, ptr_q} + W1;
    sum_mid = {1'b0, ptr_q} + W2;
    state_d = state_q;
    ptr_d = ptr_q;
    r_d = r_q;
    c_d = c_q;
    rd_en_d = acc && r_q >= 8'd2;
    win_valid_d = rd_en_d && c_q >= 8'd2;
    bot_d = acc ? ptr_q : bot_q;
    top_d = !acc ? top_q : sum_top >= DEP5 ? 4'(sum_top - DEP5) : sum_top[3:0];
    mid_d = !acc ? mid_q : sum_mid >= DEP5 ? 4'(sum_mid - DEP5) : sum_mid[3:0];
    win_row_d = win_valid_d ? r_q - 8'd2 : win_row_q;
    win_col_d = win_valid_d ? c_q - 8'd2 : win_col_q;
    if (state_q == IDLE && start) begin
      state_d = STREAM;
      ptr_d = '0;
      r_d = '0;
      c_d = '0;
    end
    if (state_q == FLUSH) state_d = IDLE;
    if (acc) begin
      ptr_d = ptr_q == PTR_MAX ? 4'd0 : ptr_q + 4'd1;
      c_d = last_col ? 8'd0 : c_q + 8'd1;
      r_d = last_col ? r_q + 8'd1 : r_q;
      if (last_col && r_q == R_MAX) state_d = FLUSH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      r_q <= '0;
      c_q <= '0;
      rd_en_q <= 1'b0;
      win_valid_q <= 1'b0;
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      r_q <= r_d;
      c_q <= c_d;
      rd_en_q <= rd_en_d;
      win_valid_q <= win_valid_d;
      top_q <= top_d;
      mid_q <= mid_d;
      bot_q <= bot_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end
  assign wr_en = acc;
  assign wr_addr = ptr_q;
  assign rd_en = rd_en_q;
  assign rd_addr_top = top_q;
  assign rd_addr_mid = mid_q;
  assign rd_addr_bot = bot_q;
  assign win_valid = win_valid_q;
  assign win_row = win_row_q;
  assign win_col = win_col_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FLUSH;
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: randomized frames checked against a pixel-index reference model
module tb_conv_window_sequencer;
  localparam int W = 5;
  localparam int H = 5;
  localparam int D = 3 * W;
  logic clk = 1'b0, rst_n, start, stall, in_valid;
  logic in_ready, wr_en, rd_en, win_valid, busy, done;
  logic [3:0] wr_addr, rd_addr_top, rd_addr_mid, rd_addr_bot;
  logic [7:0] win_row, win_col;
  int n_tests = 0, n_fail = 0;
  int ph, n, a_top, a_mid, a_bot, l_row, l_col, p_acc, p_n, cnt_wr, cnt_rd, cnt_win;
  conv_window_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en),
    .rd_addr_top(rd_addr_top), .rd_addr_mid(rd_addr_mid), .rd_addr_bot(rd_addr_bot),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    ph = 0; n = 0; a_top = 0; a_mid = 0; a_bot = 0; l_row = 0; l_col = 0; p_acc = 0; p_n = 0;
  endtask
  task automatic cyc();
    int acc, pr, pc;
    #3;
    acc = (ph == 1 && !stall && in_valid) ? 1 : 0;
    pr = p_n / W;
    pc = p_n % W;
    cnt_wr += int'(wr_en);
    cnt_rd += int'(rd_en);
    cnt_win += int'(win_valid);
    chk("in_ready", int'(in_ready), (ph == 1 && !stall) ? 1 : 0);
    chk("wr_en", int'(wr_en), acc);
    if (acc == 1) chk("wr_addr", int'(wr_addr), n % D);
    chk("busy", int'(busy), ph != 0 ? 1 : 0);
    chk("done", int'(done), ph == 2 ? 1 : 0);
    chk("rd_en", int'(rd_en), (p_acc == 1 && pr >= 2) ? 1 : 0);
    chk("win_valid", int'(win_valid), (p_acc == 1 && pr >= 2 && pc >= 2) ? 1 : 0);
    chk("rd_top", int'(rd_addr_top), a_top);
    chk("rd_mid", int'(rd_addr_mid), a_mid);
    chk("rd_bot", int'(rd_addr_bot), a_bot);
    chk("win_row", int'(win_row), l_row);
    chk("win_col", int'(win_col), l_col);
    if (ph == 2) begin
      chk("tot_wr", cnt_wr, W * H);
      chk("tot_rd", cnt_rd, W * (H - 2));
      chk("tot_win", cnt_win, (W - 2) * (H - 2));
    end
    @(posedge clk);
    p_acc = acc;
    p_n = n;
    if (acc == 1) begin
      a_bot = n % D;
      a_mid = (n + D - W) % D;
      a_top = (n + D - 2 * W) % D;
      if (n / W >= 2 && n % W >= 2) begin
        l_row = n / W - 2;
        l_col = n % W - 2;
      end
    end
    if (ph == 0 && start) begin
      ph = 1; n = 0; cnt_wr = 0; cnt_rd = 0; cnt_win = 0;
    end else if (ph == 2) ph = 0;
    else if (acc == 1) begin
      if (n == W * H - 1) ph = 2;
      n++;
    end
    #1;
  endtask
  initial begin
    int stall_cnt, budget;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; in_valid = 1'b0;
    cnt_wr = 0; cnt_rd = 0; cnt_win = 0;
    model_reset();
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (2) cyc();
    for (int f = 0; f < 8; f++) begin
      start = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      stall = 1'b0;
      cyc();
      start = 1'b0;
      stall_cnt = 0;
      budget = 0;
      while (ph != 0 && budget < 500) begin
        if (f == 0) begin
          in_valid = 1'b1; stall = 1'b0;
        end else if (f == 1) begin
          in_valid = 1'b1;
          stall = (n == 7 && stall_cnt < 4) ? 1'b1 : 1'b0;
          stall_cnt += int'(stall);
        end else if (f == 2) begin
          in_valid = ~in_valid; stall = 1'b0;
        end else begin
          in_valid = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
          stall = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
        end
        start = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
        if (f == 5 && n == 12) begin
          #2 rst_n = 1'b0;
          #1;
          chk("arst_busy", int'(busy), 0);
          chk("arst_ready", int'(in_ready), 0);
          chk("arst_wr_en", int'(wr_en), 0);
          chk("arst_wr_addr", int'(wr_addr), 0);
          chk("arst_rd_en", int'(rd_en), 0);
          chk("arst_rd_mid", int'(rd_addr_mid), 0);
          chk("arst_win", int'(win_valid), 0);
          chk("arst_win_row", int'(win_row), 0);
          chk("arst_done", int'(done), 0);
          @(negedge clk);
          rst_n = 1'b1;
          start = 1'b0;
          in_valid = 1'b1;
          model_reset();
          @(posedge clk);
          #1;
          repeat (3) cyc();
          break;
        end
        cyc();
        start = 1'b0;
        budget++;
      end
      if (budget >= 500) chk("frame_timeout", budget, 0);
      in_valid = 1'b0;
      start = 1'b0;
      if (f % 2 == 0) cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
